// File: rtl/amba3_apb_slave_regs_pkg.sv
// pkg_amba3: shared types, limits and address helpers for the APB3 slave register bank.
package pkg_amba3;
  typedef enum logic {IDLE, ACCESS} apb_slave_state_t;
  localparam int APB_MAX_WAIT = 15;
  function automatic int apb_word_lsb(input int data_bits);
    return $clog2(data_bits / 8);
  endfunction
endpackage

// File: rtl/amba3_apb_slave_regs_wait_ctrl.sv
// amba3_apb_wait_ctrl: APB3 IDLE/ACCESS FSM, wait-state counter and registered pready.
module amba3_apb_wait_ctrl
  import pkg_amba3::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic setup,
  output logic done,
  output logic load,
  output logic clear
);
  localparam int CW = $clog2(APB_MAX_WAIT + 1);
  apb_slave_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic pready_nxt;
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state <= IDLE;
      cnt <= '0;
      pready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      pready <= pready_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    pready_nxt = pready;
    if (state == IDLE) begin
      if (psel && !penable) begin
        state_nxt = ACCESS;
        cnt_nxt = CW'(WAIT_STATES);
        pready_nxt = (WAIT_STATES == 0);
      end
    end else if (!psel || (penable && pready)) begin
      state_nxt = IDLE;
      pready_nxt = 1'b0;
    end else if (penable) begin
      cnt_nxt = cnt - CW'(1);
      pready_nxt = (cnt == CW'(1));
    end
  end
  assign setup = (state == IDLE) && psel && !penable;
  assign done = (state == ACCESS) && psel && penable && pready;
  // load marks the edge that raises pready; clear marks any edge leaving it low
  assign load = pready_nxt && !pready;
  assign clear = !pready_nxt;
endmodule

// File: rtl/amba3_apb_slave_regs.sv
// amba3_apb_slave_regs: parametrised APB3 slave register bank with wait states and RO registers.
// Define AMBA3_APB_PSLVERR_EN to drive pslverr from invalid transfers; otherwise pslverr is tied to 0.
module amba3_apb_slave_regs
  import pkg_amba3::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int NUM_REGS = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [DATA_BITS-1:0] RESET_VALUE = '0
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic [ADDR_BITS-1:0] paddr,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  input  logic [DATA_BITS-1:0] pwdata,
  output logic pready,
  output logic [DATA_BITS-1:0] prdata,
  output logic pslverr,
  output logic [NUM_REGS*DATA_BITS-1:0] reg_q,
  input  logic [NUM_REGS*DATA_BITS-1:0] ro_d,
  output logic [NUM_REGS-1:0] wr_pulse
);
  localparam int LSB = apb_word_lsb(DATA_BITS);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  logic setup, done, load, clear;
  logic [ADDR_BITS-1:0] word;
  logic [IW-1:0] cur_idx, lat_idx, idx;
  logic cur_ok, lat_ok, lat_wr, ok, wr;
  logic [DATA_BITS-1:0] lat_wdata, rd_val;
  logic [DATA_BITS-1:0] regs [NUM_REGS];
  amba3_apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .pclk(pclk),
    .preset_n(preset_n),
    .psel(psel),
    .penable(penable),
    .pready(pready),
    .setup(setup),
    .done(done),
    .load(load),
    .clear(clear)
  );
  assign word = paddr >> LSB;
  assign cur_idx = word[IW-1:0];
  assign cur_ok = (word < ADDR_BITS'(NUM_REGS)) && ((paddr & ADDR_BITS'((1 << LSB) - 1)) == '0)
                  && !(pwrite && RO_MASK[cur_idx]);
  // zero-wait transfers raise pready on the SETUP edge, before the latches hold the request
  assign idx = setup ? cur_idx : lat_idx;
  assign ok = setup ? cur_ok : lat_ok;
  assign wr = setup ? pwrite : lat_wr;
  assign rd_val = (ok && !wr) ? reg_q[idx*DATA_BITS +: DATA_BITS] : '0;
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      lat_idx <= '0;
      lat_ok <= 1'b0;
      lat_wr <= 1'b0;
      lat_wdata <= '0;
    end else if (setup) begin
      lat_idx <= cur_idx;
      lat_ok <= cur_ok;
      lat_wr <= pwrite;
      lat_wdata <= pwdata;
    end
  end
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) prdata <= '0;
    else prdata <= load ? rd_val : clear ? '0 : prdata;
  end
`ifdef AMBA3_APB_PSLVERR_EN
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) pslverr <= 1'b0;
    else pslverr <= load ? !ok : clear ? 1'b0 : pslverr;
  end
`else
  assign pslverr = 1'b0;
`endif
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (done && lat_wr && lat_ok) begin
        regs[lat_idx] <= lat_wdata;
        wr_pulse[lat_idx] <= 1'b1;
      end
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_BITS +: DATA_BITS] = RO_MASK[g] ? ro_d[g*DATA_BITS +: DATA_BITS] : regs[g];
  end
endmodule

// File: tb/tb_amba3_apb_slave_regs.sv
// tb_amba3_apb_slave_regs: directed bench for a zero-wait bank with RO register 3 and a 3-wait bank.
module tb_amba3_apb_slave_regs;
`ifdef AMBA3_APB_PSLVERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  logic pclk = 1'b0;
  logic preset_n, psel0, psel1, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [511:0] ro_d;
  logic pready0, pslverr0, pready1, pslverr1;
  logic [31:0] prdata0, prdata1;
  logic [511:0] reg_q0, reg_q1;
  logic [15:0] wr_pulse0, wr_pulse1;
  int passed = 0;
  int total = 0;
  always #5 pclk = ~pclk;
  amba3_apb_slave_regs #(.WAIT_STATES(0), .RO_MASK(16'h0008), .RESET_VALUE(32'h0000_1111)) u0 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
    .reg_q(reg_q0), .ro_d(ro_d), .wr_pulse(wr_pulse0)
  );
  amba3_apb_slave_regs #(.WAIT_STATES(3), .RO_MASK(16'h0000), .RESET_VALUE(32'hCAFE_0000)) u1 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready1), .prdata(prdata1), .pslverr(pslverr1),
    .reg_q(reg_q1), .ro_d(ro_d), .wr_pulse(wr_pulse1)
  );
  function automatic logic [31:0] slot(input logic [511:0] q, input int i);
    return q[i*32 +: 32];
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask
  task automatic setup(input logic s, input logic [31:0] a, input logic w, input logic [31:0] d);
    psel0 = !s;
    psel1 = s;
    penable = 1'b0;
    paddr = a;
    pwrite = w;
    pwdata = d;
    cyc();
    penable = 1'b1;
  endtask
  task automatic idle();
    psel0 = 1'b0;
    psel1 = 1'b0;
    penable = 1'b0;
  endtask
  initial begin
    preset_n = 1'b0;
    idle();
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    ro_d = '0;
    ro_d[3*32 +: 32] = 32'h1234;
    repeat (2) cyc();
    chk("rst_pready", pready0, 0);
    chk("rst_prdata", prdata0, 0);
    chk("rst_pslverr", pslverr0, 0);
    chk("rst_wr_pulse", wr_pulse0, 0);
    chk("rst_reg2", slot(reg_q0, 2), 32'h1111);
    chk("rst_ro3", slot(reg_q0, 3), 32'h1234);
    chk("rst_u1_reg0", slot(reg_q1, 0), 32'hCAFE_0000);
    #3 preset_n = 1'b1;
    cyc();
    setup(0, 32'h08, 1, 32'hDEAD_BEEF);
    chk("wr_pready", pready0, 1);
    chk("wr_pslverr", pslverr0, 0);
    chk("wr_prdata", prdata0, 0);
    chk("wr_reg_before", slot(reg_q0, 2), 32'h1111);
    cyc();
    chk("wr_done_pready", pready0, 0);
    chk("wr_reg2", slot(reg_q0, 2), 32'hDEAD_BEEF);
    chk("wr_pulse", wr_pulse0, 16'h0004);
    setup(0, 32'h08, 0, 32'h0);
    chk("rd_pready", pready0, 1);
    chk("rd_prdata", prdata0, 32'hDEAD_BEEF);
    chk("rd_pslverr", pslverr0, 0);
    chk("pulse_one_cycle", wr_pulse0, 0);
    cyc();
    chk("rd_done_pready", pready0, 0);
    chk("rd_done_prdata", prdata0, 0);
    setup(0, 32'h40, 0, 32'h0);
    chk("oor_pready", pready0, 1);
    chk("oor_prdata", prdata0, 0);
    chk("oor_pslverr", pslverr0, ERR);
    cyc();
    chk("oor_pslverr_clear", pslverr0, 0);
    setup(0, 32'h02, 1, 32'h55);
    chk("mis_pslverr", pslverr0, ERR);
    cyc();
    chk("mis_reg0", slot(reg_q0, 0), 32'h1111);
    chk("mis_pulse", wr_pulse0, 0);
    setup(0, 32'h0C, 1, 32'hFFFF);
    chk("ro_wr_pslverr", pslverr0, ERR);
    cyc();
    chk("ro_wr_reg3", slot(reg_q0, 3), 32'h1234);
    chk("ro_wr_pulse", wr_pulse0, 0);
    setup(0, 32'h0C, 0, 32'h0);
    chk("ro_rd_prdata", prdata0, 32'h1234);
    chk("ro_rd_pslverr", pslverr0, 0);
    cyc();
    setup(0, 32'h10, 0, 32'h0);
    chk("rd_reset_val", prdata0, 32'h1111);
    cyc();
    setup(1, 32'h04, 0, 32'h0);
    chk("w3_cycle1", pready1, 0);
    chk("w3_u0_quiet", pready0, 0);
    cyc();
    chk("w3_cycle2", pready1, 0);
    cyc();
    chk("w3_cycle3", pready1, 0);
    chk("w3_prdata_low", prdata1, 0);
    cyc();
    chk("w3_cycle4", pready1, 1);
    chk("w3_prdata", prdata1, 32'hCAFE_0000);
    cyc();
    chk("w3_done", pready1, 0);
    setup(1, 32'h04, 1, 32'h1357);
    pwdata = 32'h0;
    paddr = 32'h08;
    repeat (3) cyc();
    chk("lat_pready", pready1, 1);
    cyc();
    chk("lat_reg1", slot(reg_q1, 1), 32'h1357);
    chk("lat_reg2", slot(reg_q1, 2), 32'hCAFE_0000);
    chk("lat_pulse", wr_pulse1, 16'h0002);
    setup(1, 32'h00, 1, 32'h0BAD);
    cyc();
    idle();
    cyc();
    chk("ab_pready", pready1, 0);
    chk("ab_reg0", slot(reg_q1, 0), 32'hCAFE_0000);
    chk("ab_pulse", wr_pulse1, 0);
    cyc();
    chk("ab_pulse_late", wr_pulse1, 0);
    setup(1, 32'h00, 0, 32'h0);
    repeat (3) cyc();
    chk("ab_next_pready", pready1, 1);
    chk("ab_next_prdata", prdata1, 32'hCAFE_0000);
    cyc();
    setup(1, 32'h08, 1, 32'h77);
    repeat (3) cyc();
    chk("rm_pready_before", pready1, 1);
    preset_n = 1'b0;
    #1;
    chk("rm_pready", pready1, 0);
    chk("rm_reg1", slot(reg_q1, 1), 32'hCAFE_0000);
    chk("rm_u0_reg2", slot(reg_q0, 2), 32'h1111);
    idle();
    #2 preset_n = 1'b1;
    cyc();
    chk("rm_write_lost", slot(reg_q1, 2), 32'hCAFE_0000);
    setup(1, 32'h08, 1, 32'h77);
    repeat (3) cyc();
    chk("rm_after_pready", pready1, 1);
    cyc();
    chk("rm_after_reg2", slot(reg_q1, 2), 32'h77);
    chk("rm_after_pulse", wr_pulse1, 16'h0004);
    idle();
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
